// File: rtl/agp32_accel_unit.sv
// agp32_accel_unit: queued multi-mode accelerator for the agp32 pipeline.
// Arguments (operand + 2-bit mode) enter a DEPTH-entry FIFO, are processed in
// order by a LATENCY-cycle engine and returned over a valid/ready handshake.
// Optional feature macro: ACCEL_FLUSH_EN adds a synchronous flush input.
module agp32_accel_unit #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arg_valid,
  output logic                       arg_ready,
  input  logic [DATA_W-1:0]          arg_data,
  input  logic [1:0]                 arg_mode,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
`ifdef ACCEL_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int HW   = DATA_W / 2;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  logic              flush_w;
`ifdef ACCEL_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Each FIFO entry carries {mode, operand}
  logic [DATA_W+1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]   count_q;
  logic [DATA_W-1:0] op_q, res_data_q, result_w;
  logic [1:0]        mode_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              res_valid_q;
  state_t            state_q, state_d;
  logic              push_w, pop_w, finish_w;

  assign arg_ready = (count_q != CNTW'(DEPTH));
  assign push_w    = arg_valid && arg_ready && !flush_w;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign count     = count_q;
  assign busy      = (count_q != '0) || (state_q != S_IDLE);

  // Operation select on the latched operand
  always_comb begin
    logic [HW-1:0] hi, lo;
    hi       = op_q[DATA_W-1:HW];
    lo       = op_q[HW-1:0];
    result_w = '0;
    case (mode_q)
      2'd0: result_w = {{(DATA_W-HW){1'b0}}, hi + lo};
      2'd1: result_w = DATA_W'(hi) * DATA_W'(lo);
      2'd2: for (int i = 0; i < DATA_W; i++) result_w = result_w + DATA_W'(op_q[i]);
      default: for (int i = 0; i < DATA_W/8; i++)
        result_w[8*i +: 8] = op_q[DATA_W-8-8*i +: 8];
    endcase
  end

  // Engine next-state: pops the FIFO in IDLE or on a consumed result in DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop_w    = 1'b0;
    finish_w = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        pop_w   = 1'b1;
        cnt_d   = CW'(LATENCY-1);
        state_d = S_COMPUTE;
      end
      S_COMPUTE: if (cnt_q == '0) begin
        finish_w = 1'b1;
        state_d  = S_DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      S_DONE: if (res_ready) begin
        if (count_q != '0) begin
          pop_w   = 1'b1;
          cnt_d   = CW'(LATENCY-1);
          state_d = S_COMPUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides every other event
    if (flush_w) begin
      state_d  = S_IDLE;
      pop_w    = 1'b0;
      finish_w = 1'b0;
    end
  end

  // Engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= {arg_mode, arg_data};
  end

  // FIFO pointers/occupancy, operand latch and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op_q        <= '0;
      mode_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else if (flush_w) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        {mode_q, op_q} <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CNTW'(push_w) - CNTW'(pop_w);
      if (finish_w) begin
        res_valid_q <= 1'b1;
        res_data_q  <= result_w;
      end else if (state_q == S_DONE && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

endmodule
